// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - widths, defaults and shared types for the SRAM arbiter
package sram_arb_pkg;

  localparam int ADDR_W           = 18;
  localparam int DATA_W           = 16;
  localparam int DEF_NUM_PORTS    = 3;
  localparam int DEF_READ_LATENCY = 2;
  localparam int PORT_IDX_W       = 4;
  localparam int MAX_PORTS        = 1 << PORT_IDX_W;

  typedef logic [PORT_IDX_W-1:0] port_idx_t;

  typedef enum logic {ARB, LOCKED} arb_state_t;

  typedef struct packed {
    logic      valid;
    port_idx_t port;
  } rd_tag_t;

  // Round-robin successor over ports 1..num_ports-1; port 0 is never in the ring.
  function automatic port_idx_t rr_wrap(port_idx_t p, int num_ports);
    if (int'(p) + 1 >= num_ports) return port_idx_t'(1);
    return p + port_idx_t'(1);
  endfunction

endpackage

// File: rtl/sram_tag_pipe.sv
// rtl/sram_tag_pipe.sv - read-return tag shift register, one stage per SRAM latency cycle
module sram_tag_pipe
  import sram_arb_pkg::*;
#(
  parameter int DEPTH = DEF_READ_LATENCY
) (
  input  logic    Clock_50,
  input  logic    Resetn,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t stage [DEPTH];

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - multi-port SRAM arbiter: port 0 priority, round-robin 1..N-1, lockable grants
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_PORTS    = DEF_NUM_PORTS,
  parameter int READ_LATENCY = DEF_READ_LATENCY
) (
  input  logic                              Clock_50,
  input  logic                              Resetn,
  input  logic [NUM_PORTS-1:0]              req_i,
  input  logic [NUM_PORTS-1:0]              lock_i,
  input  logic [NUM_PORTS-1:0]              we_n_i,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]  addr_i,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]  wdata_i,
  output logic [NUM_PORTS-1:0]              gnt_o,
  output logic [NUM_PORTS-1:0]              rvalid_o,
  output logic [DATA_W-1:0]                 rdata_o,
  output logic [ADDR_W-1:0]                 SRAM_address_o,
  output logic [DATA_W-1:0]                 SRAM_write_data_o,
  output logic                              SRAM_we_n_o,
  input  logic [DATA_W-1:0]                 SRAM_read_data_i
);

  arb_state_t            state;
  port_idx_t             owner;
  port_idx_t             rr_ptr;
  port_idx_t             gnt_idx;
  port_idx_t             cand;
  logic                  gnt_any;
  logic [MAX_PORTS-1:0]  req_x;
  logic [MAX_PORTS-1:0]  lock_x;
  logic [MAX_PORTS-1:0]  wen_x;
  logic [ADDR_W-1:0]     sel_addr;
  logic [DATA_W-1:0]     sel_wdata;
  rd_tag_t               issue_tag;
  rd_tag_t               ret_tag;

  // Widened copies so a port index can select a bit without a width mismatch.
  assign req_x  = MAX_PORTS'(req_i);
  assign lock_x = MAX_PORTS'(lock_i);
  assign wen_x  = MAX_PORTS'(we_n_i);

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = rr_ptr;
    if (state == LOCKED) begin
      gnt_any = req_x[owner];
      gnt_idx = owner;
    end else if (req_x[0]) begin
      gnt_any = 1'b1;
    end else begin
      for (int k = 0; k < NUM_PORTS - 1; k++) begin
        if (!gnt_any && req_x[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
        cand = rr_wrap(cand, NUM_PORTS);
      end
    end
  end

  always_comb begin
    gnt_o     = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt_idx == port_idx_t'(i)) begin
        gnt_o[i]  = gnt_any && Resetn;
        sel_addr  = addr_i[i];
        sel_wdata = wdata_i[i];
      end
    end
  end

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      state             <= ARB;
      owner             <= '0;
      rr_ptr            <= port_idx_t'(1);
      SRAM_address_o    <= '0;
      SRAM_write_data_o <= '0;
      SRAM_we_n_o       <= 1'b1;
      issue_tag         <= '0;
    end else begin
      SRAM_we_n_o <= 1'b1;
      issue_tag   <= '0;
      if (gnt_any) begin
        SRAM_address_o    <= sel_addr;
        SRAM_write_data_o <= sel_wdata;
        SRAM_we_n_o       <= wen_x[gnt_idx];
        issue_tag         <= '{valid: wen_x[gnt_idx], port: gnt_idx};
        if (gnt_idx != '0) rr_ptr <= rr_wrap(gnt_idx, NUM_PORTS);
      end
      case (state)
        ARB: begin
          if (gnt_any && lock_x[gnt_idx]) begin
            state <= LOCKED;
            owner <= gnt_idx;
          end
        end
        LOCKED: begin
          if (!req_x[owner] || !lock_x[owner]) state <= ARB;
        end
        default: state <= ARB;
      endcase
    end
  end

  // The issue tag is aligned with the address on the SRAM bus, so the pipe adds exactly READ_LATENCY.
  sram_tag_pipe #(
    .DEPTH (READ_LATENCY)
  ) u_tag_pipe (
    .Clock_50 (Clock_50),
    .Resetn   (Resetn),
    .tag_in   (issue_tag),
    .tag_out  (ret_tag)
  );

  always_comb begin
    rvalid_o = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      rvalid_o[i] = ret_tag.valid && (ret_tag.port == port_idx_t'(i));
    end
  end

  assign rdata_o = (|rvalid_o) ? SRAM_read_data_i : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - scoreboard bench for sram_arbiter with an SRAM emulator
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  localparam int NP = 3;
  localparam int RL = 2;

  logic                       Clock_50 = 1'b0;
  logic                       Resetn   = 1'b0;
  logic [NP-1:0]              req_i    = '0;
  logic [NP-1:0]              lock_i   = '0;
  logic [NP-1:0]              we_n_i   = '1;
  logic [NP-1:0][ADDR_W-1:0]  addr_i   = '0;
  logic [NP-1:0][DATA_W-1:0]  wdata_i  = '0;
  logic [NP-1:0]              gnt_o;
  logic [NP-1:0]              rvalid_o;
  logic [DATA_W-1:0]          rdata_o;
  logic [ADDR_W-1:0]          SRAM_address_o;
  logic [DATA_W-1:0]          SRAM_write_data_o;
  logic                       SRAM_we_n_o;
  logic [DATA_W-1:0]          SRAM_read_data_i = '0;

  sram_arbiter #(.NUM_PORTS(NP), .READ_LATENCY(RL)) dut (
    .Clock_50          (Clock_50),
    .Resetn            (Resetn),
    .req_i             (req_i),
    .lock_i            (lock_i),
    .we_n_i            (we_n_i),
    .addr_i            (addr_i),
    .wdata_i           (wdata_i),
    .gnt_o             (gnt_o),
    .rvalid_o          (rvalid_o),
    .rdata_o           (rdata_o),
    .SRAM_address_o    (SRAM_address_o),
    .SRAM_write_data_o (SRAM_write_data_o),
    .SRAM_we_n_o       (SRAM_we_n_o),
    .SRAM_read_data_i  (SRAM_read_data_i)
  );

  always #10 Clock_50 = ~Clock_50;

  int cyc = 0;
  always @(posedge Clock_50) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct { logic [NP-1:0] port; logic [DATA_W-1:0] data; int cyc; } rd_exp_t;
  typedef struct { logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } wr_exp_t;

  logic [NP-1:0] gnt_q [$];
  rd_exp_t       rd_q  [$];
  wr_exp_t       wr_q  [$];

  // SRAM emulator: read data for the address presented RL cycles earlier.
  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
  logic [ADDR_W-1:0] ahist [RL+1];

  initial begin
    for (int i = 0; i <= RL; i++) ahist[i] = '0;
    mem[18'h00100] = 16'hBEEF;
    mem[18'h00000] = 16'h1111;
    mem[18'h00001] = 16'h2222;
    mem[18'h00002] = 16'h3333;
  end

  always @(posedge Clock_50) begin
    #1;
    if (!SRAM_we_n_o) mem[SRAM_address_o] = SRAM_write_data_o;
    for (int i = RL; i > 0; i--) ahist[i] = ahist[i-1];
    ahist[0] = SRAM_address_o;
    SRAM_read_data_i = mem.exists(ahist[RL]) ? mem[ahist[RL]] : 16'hDEAD;
  end

  int wr_run  = 0;
  int max_run = 0;
  logic [NP-1:0] g_e;
  rd_exp_t r_e;
  wr_exp_t w_e;

  always @(negedge Clock_50) begin
    if (!Resetn) begin
      wr_run = 0;
    end else begin
      if (gnt_o != '0) begin
        if (gnt_q.size() == 0) check("gnt_unexpected", gnt_o, 0);
        else begin
          g_e = gnt_q.pop_front();
          check("gnt", gnt_o, g_e);
        end
      end
      if (rvalid_o != '0) begin
        if (rd_q.size() == 0) check("rvalid_unexpected", rvalid_o, 0);
        else begin
          r_e = rd_q.pop_front();
          check("rvalid", rvalid_o, r_e.port);
          check("rdata", rdata_o, r_e.data);
          check("rvalid_cycle", cyc, r_e.cyc);
        end
      end
      if (!SRAM_we_n_o) begin
        wr_run++;
        if (wr_run > max_run) max_run = wr_run;
        if (wr_q.size() == 0) check("sram_write_unexpected", {SRAM_address_o, SRAM_write_data_o}, 0);
        else begin
          w_e = wr_q.pop_front();
          check("sram_wr_addr", SRAM_address_o, w_e.a);
          check("sram_wr_data", SRAM_write_data_o, w_e.d);
        end
      end else begin
        wr_run = 0;
      end
    end
  end

  // Every port presents address a and data d+port; eg is the hand-expected grant, erd the read data.
  task automatic step(input logic [NP-1:0] req, input logic [NP-1:0] lock, input logic [NP-1:0] wen,
                      input logic [NP-1:0] eg, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      input logic [DATA_W-1:0] erd);
    @(posedge Clock_50);
    #1;
    req_i  = req;
    lock_i = lock;
    we_n_i = wen;
    for (int i = 0; i < NP; i++) begin
      addr_i[i]  = a;
      wdata_i[i] = d + DATA_W'(i);
    end
    if (eg != '0) begin
      gnt_q.push_back(eg);
      for (int i = 0; i < NP; i++) begin
        if (eg[i]) begin
          if (wen[i]) rd_q.push_back('{eg, erd, cyc + 1 + RL});
          else        wr_q.push_back('{a, d + DATA_W'(i)});
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(3'b000, 3'b000, 3'b111, 3'b000, '0, '0, '0);
  endtask

  initial begin
    req_i = 3'b111;
    #15;
    check("rst_gnt", gnt_o, 3'b000);
    check("rst_rvalid", rvalid_o, 3'b000);
    check("rst_rdata", rdata_o, 16'h0000);
    check("rst_we_n", SRAM_we_n_o, 1'b1);
    check("rst_addr", SRAM_address_o, 18'h0);
    check("rst_wdata", SRAM_write_data_o, 16'h0);
    req_i = '0;
    @(posedge Clock_50); #1;
    Resetn = 1'b1;

    // All requesting: port 0 wins while it stays up, then ports 1 and 2 alternate.
    step(3'b111, 3'b000, 3'b000, 3'b001, 18'h00200, 16'hA000, '0);
    step(3'b111, 3'b000, 3'b000, 3'b001, 18'h00201, 16'hA010, '0);
    step(3'b111, 3'b000, 3'b000, 3'b001, 18'h00202, 16'hA020, '0);
    step(3'b111, 3'b000, 3'b000, 3'b001, 18'h00203, 16'hA030, '0);
    step(3'b110, 3'b000, 3'b000, 3'b010, 18'h00204, 16'hA040, '0);
    step(3'b110, 3'b000, 3'b000, 3'b100, 18'h00205, 16'hA050, '0);
    step(3'b110, 3'b000, 3'b000, 3'b010, 18'h00206, 16'hA060, '0);
    step(3'b110, 3'b000, 3'b000, 3'b100, 18'h00207, 16'hA070, '0);
    idle(2);

    // Single read by port 1, data back three cycles after the grant.
    step(3'b010, 3'b000, 3'b111, 3'b010, 18'h00100, 16'h0000, 16'hBEEF);
    idle(5);

    // Port 2 locks for five writes while port 0 waits.
    max_run = 0;
    step(3'b100, 3'b100, 3'b000, 3'b100, 18'h06C00, 16'hC000, '0);
    for (int k = 1; k < 5; k++)
      step(3'b101, 3'b100, 3'b000, 3'b100, 18'h06C00 + ADDR_W'(k), 16'hC000 + DATA_W'(k), '0);
    step(3'b001, 3'b000, 3'b000, 3'b000, 18'h00300, 16'hD000, '0);
    step(3'b001, 3'b000, 3'b000, 3'b001, 18'h00300, 16'hD000, '0);
    idle(3);
    check("lock_write_run", max_run, 5);

    // Back-to-back reads from each port return in order, one per cycle.
    step(3'b001, 3'b000, 3'b111, 3'b001, 18'h00000, '0, 16'h1111);
    step(3'b010, 3'b000, 3'b111, 3'b010, 18'h00001, '0, 16'h2222);
    step(3'b100, 3'b000, 3'b111, 3'b100, 18'h00002, '0, 16'h3333);
    idle(5);

    // Idle cycle: no write strobe.
    idle(1);
    @(negedge Clock_50);
    check("idle_we_n", SRAM_we_n_o, 1'b1);

    // Reset one cycle after a read grant drops the read.
    step(3'b010, 3'b000, 3'b111, 3'b010, 18'h00155, 16'h5A5A, '0);
    void'(rd_q.pop_back());
    @(posedge Clock_50); #3;
    Resetn = 1'b0;
    #1;
    check("async_rst_we_n", SRAM_we_n_o, 1'b1);
    check("async_rst_addr", SRAM_address_o, 18'h0);
    check("async_rst_wdata", SRAM_write_data_o, 16'h0);
    check("async_rst_gnt", gnt_o, 3'b000);
    check("async_rst_rvalid", rvalid_o, 3'b000);
    check("async_rst_rdata", rdata_o, 16'h0);
    req_i = '0;
    repeat (2) @(posedge Clock_50);
    #1;
    Resetn = 1'b1;
    idle(6);

    // Round-robin pointer restarts at port 1.
    step(3'b110, 3'b000, 3'b000, 3'b010, 18'h00400, 16'hE000, '0);
    idle(2);

    for (int i = 0; i < 20 && (gnt_q.size() + rd_q.size() + wr_q.size()) != 0; i++)
      @(posedge Clock_50);
    check("gnt_queue_drained", gnt_q.size(), 0);
    check("rd_queue_drained", rd_q.size(), 0);
    check("wr_queue_drained", wr_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
